// File: rtl/mips_alu_seq_pkg.sv
// Opcode map, controller state type and op-class helper shared by the
// sequential MIPS execute-stage ALU.
package mips_alu_seq_pkg;

  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_SUB   = 4'h1;
  localparam logic [3:0] OP_ADD_2 = 4'h2;
  localparam logic [3:0] OP_ADD_3 = 4'h3;
  localparam logic [3:0] OP_ADD_4 = 4'h4;
  localparam logic [3:0] OP_AND   = 4'h5;
  localparam logic [3:0] OP_XOR   = 4'h6;
  localparam logic [3:0] OP_OR    = 4'h7;
  localparam logic [3:0] OP_SLT   = 4'h8;
  localparam logic [3:0] OP_SLL   = 4'h9;
  localparam logic [3:0] OP_SRL   = 4'hA;
  localparam logic [3:0] OP_SRA   = 4'hB;
  localparam logic [3:0] OP_MUL   = 4'hC;
  localparam logic [3:0] OP_DIVU  = 4'hD;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic is_multi(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mips_alu_seq_if.sv
// Request/response bundle between the control unit (master) and the ALU (slave).
interface mips_alu_seq_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic             kill;
  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] im;
  logic             ALUsrc;
  logic [3:0]       ALUop;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] ALU_out;
  logic [WIDTH-1:0] ALU_hi;
  logic             zero;
  logic             ovf;
  logic             div0;
  logic             illegal;

  modport master (
    output in_valid, kill, s1, s2, im, ALUsrc, ALUop, out_ready,
    input  in_ready, out_valid, ALU_out, ALU_hi, zero, ovf, div0, illegal
  );

  modport slave (
    input  in_valid, kill, s1, s2, im, ALUsrc, ALUop, out_ready,
    output in_ready, out_valid, ALU_out, ALU_hi, zero, ovf, div0, illegal
  );
endinterface

// File: rtl/mips_alu_seq_muldiv.sv
// Iterative one-bit-per-cycle unsigned multiplier (shift-add) and restoring
// divider sharing one {hi, lo} register pair.
module mips_alu_seq_muldiv #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             kill_i,
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] lo_o,
  output logic [WIDTH-1:0] hi_o,
  output logic             div0_o
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] hi_q, lo_q, b_q;
  logic [CW-1:0]    cnt_q;
  logic             run_q, is_div_q, div0_q;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH-1:0] div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] hi_d, lo_d;

  // A zero divisor needs no special case: every step "subtracts" zero, so the
  // quotient fills with ones and the dividend shifts whole into the remainder.
  always_comb begin
    mul_sum   = {1'b0, hi_q} + {1'b0, (lo_q[0] ? b_q : '0)};
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_diff  = div_shift[WIDTH-1:0] - b_q;
    div_ge    = div_shift >= {1'b0, b_q};
    if (is_div_q) begin
      hi_d = div_ge ? div_diff : div_shift[WIDTH-1:0];
      lo_d = {lo_q[WIDTH-2:0], div_ge};
    end else begin
      hi_d = mul_sum[WIDTH:1];
      lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
  end

  // Result is presented from the final step's next-state so the controller
  // can register it on the same edge the last bit is produced.
  assign done_o = run_q && (cnt_q == CW'(WIDTH - 1));
  assign lo_o   = lo_d;
  assign hi_o   = hi_d;
  assign div0_o = div0_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q     <= '0;
      lo_q     <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
      is_div_q <= 1'b0;
      div0_q   <= 1'b0;
    end else if (kill_i) begin
      run_q <= 1'b0;
      cnt_q <= '0;
    end else if (start_i) begin
      hi_q     <= '0;
      lo_q     <= a_i;
      b_q      <= b_i;
      is_div_q <= is_div_i;
      div0_q   <= is_div_i && (b_i == '0);
      cnt_q    <= '0;
      run_q    <= 1'b1;
    end else if (run_q) begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      cnt_q <= cnt_q + 1'b1;
      if (cnt_q == CW'(WIDTH - 1)) begin
        run_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/mips_alu_seq.sv
// Execute-stage ALU: single-cycle ops plus iterative MUL/DIVU, results held
// in output registers behind a valid/ready handshake.
//   state | meaning
//   IDLE  | no result pending, accepting requests
//   BUSY  | MUL/DIVU iterating, requests stalled
//   DONE  | result valid, held until out_ready
module mips_alu_seq
  import mips_alu_seq_pkg::*;
#(
  parameter int          WIDTH       = 16,
  parameter logic [63:0] ILLEGAL_VAL = 64'hDEAD
) (
  input logic           clk,
  input logic           rst_n,
  mips_alu_seq_if.slave bus
);

  localparam int               SHW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] ILL = WIDTH'(ILLEGAL_VAL);

  if (WIDTH < 8 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $error("mips_alu_seq: WIDTH must be a power of two and at least 8");
  end

  state_t           state_q;
  logic             out_valid_q, zero_q, ovf_q, div0_q, illegal_q;
  logic [WIDTH-1:0] alu_out_q, alu_hi_q;

  logic [WIDTH-1:0] op_a, op_b, res_d;
  logic [SHW-1:0]   shamt;
  logic             ovf_d, illegal_d;
  logic             in_ready, accept, multi;

  logic             md_done, md_div0;
  logic [WIDTH-1:0] md_lo, md_hi;

  assign op_a     = bus.s1;
  assign op_b     = bus.ALUsrc ? bus.im : bus.s2;
  assign shamt    = op_b[SHW-1:0];
  assign multi    = is_multi(bus.ALUop);
  assign in_ready = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
  assign accept   = bus.in_valid && in_ready && !bus.kill;

  always_comb begin
    res_d     = '0;
    ovf_d     = 1'b0;
    illegal_d = 1'b0;
    case (bus.ALUop)
      OP_ADD, OP_ADD_2, OP_ADD_3, OP_ADD_4: begin
        res_d = op_a + op_b;
        ovf_d = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (res_d[WIDTH-1] != op_a[WIDTH-1]);
      end
      OP_SUB: begin
        res_d = op_a - op_b;
        ovf_d = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (res_d[WIDTH-1] != op_a[WIDTH-1]);
      end
      OP_AND:  res_d = op_a & op_b;
      OP_XOR:  res_d = op_a ^ op_b;
      OP_OR:   res_d = op_a | op_b;
      OP_SLT:  res_d = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      OP_SLL:  res_d = op_a << shamt;
      OP_SRL:  res_d = op_a >> shamt;
      OP_SRA:  res_d = $signed(op_a) >>> shamt;
      OP_MUL, OP_DIVU: res_d = '0;
      default: begin
        res_d     = ILL;
        illegal_d = 1'b1;
      end
    endcase
  end

  mips_alu_seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (accept && multi),
    .kill_i   (bus.kill),
    .is_div_i (bus.ALUop == OP_DIVU),
    .a_i      (op_a),
    .b_i      (op_b),
    .done_o   (md_done),
    .lo_o     (md_lo),
    .hi_o     (md_hi),
    .div0_o   (md_div0)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      alu_out_q   <= '0;
      alu_hi_q    <= '0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      div0_q      <= 1'b0;
      illegal_q   <= 1'b0;
    end else if (bus.kill) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
    end else if (accept) begin
      if (multi) begin
        state_q     <= BUSY;
        out_valid_q <= 1'b0;
      end else begin
        state_q     <= DONE;
        out_valid_q <= 1'b1;
        alu_out_q   <= res_d;
        alu_hi_q    <= '0;
        zero_q      <= (res_d == '0);
        ovf_q       <= ovf_d;
        div0_q      <= 1'b0;
        illegal_q   <= illegal_d;
      end
    end else begin
      case (state_q)
        BUSY: begin
          if (md_done) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            alu_out_q   <= md_lo;
            alu_hi_q    <= md_hi;
            zero_q      <= (md_lo == '0);
            ovf_q       <= 1'b0;
            div0_q      <= md_div0;
            illegal_q   <= 1'b0;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.ALU_out   = alu_out_q;
  assign bus.ALU_hi    = alu_hi_q;
  assign bus.zero      = zero_q;
  assign bus.ovf       = ovf_q;
  assign bus.div0      = div0_q;
  assign bus.illegal   = illegal_q;

endmodule

// File: doc/mips_alu_seq.md
Name: mips_alu_seq

Overview:
- Parametrised next-generation execute-stage ALU for the MIPS datapath.
- Keeps the existing 4-bit opcode map and the ALUsrc immediate mux.
- Adds AND, SLT, shifts, and iterative multi-cycle MUL/DIVU.
- Results are registered behind a valid/ready handshake so the control unit can stall on long operations.

Parameters:
WIDTH, 16, datapath width; must be a power of two and at least 8.
ILLEGAL_VAL, 'hDEAD, result returned for unmapped opcodes, zero-extended or truncated to WIDTH.
SHW, $clog2(WIDTH), shift-amount width; derived, not overridden.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operation request
in_ready  output  1  block can accept a request this cycle
kill  input  1  synchronous abort (pipeline flush)
s1  input  WIDTH  operand A (rs)
s2  input  WIDTH  operand B (rt)
im  input  WIDTH  immediate, already extended upstream
ALUsrc  input  1  1 selects im as operand B, 0 selects s2
ALUop  input  4  opcode
out_valid  output  1  result valid
out_ready  input  1  consumer accepts the result
ALU_out  output  WIDTH  primary result (MUL low half, DIVU quotient)
ALU_hi  output  WIDTH  MUL high half or DIVU remainder; 0 for all other ops
zero  output  1  ALU_out == 0
ovf  output  1  signed overflow (ADD/SUB family only)
div0  output  1  DIVU with divisor 0
illegal  output  1  unmapped opcode

Behaviour:
- Opcodes:
  - 0000, 0010, 0011, 0100: ADD
  - 0001: SUB
  - 0101: AND
  - 0110: XOR
  - 0111: OR
  - 1000: SLT, signed; result is 1 or 0
  - 1001: SLL
  - 1010: SRL
  - 1011: SRA
  - 1100: MUL, unsigned, 2*WIDTH-bit product
  - 1101: DIVU
  - 1110, 1111: illegal; ALU_out = ILLEGAL_VAL, illegal = 1.
- Operand B is im when ALUsrc = 1, otherwise s2. Operands are sampled only at acceptance, i.e. when in_valid && in_ready.
- Shift amount is opB[SHW-1:0]; upper bits are ignored.
- ADD/SUB wrap modulo 2^WIDTH. ovf follows the two's-complement rule and is 0 for every other op.
- FSM states:
  - IDLE: in_ready = 1. Accepting a single-cycle op goes to DONE. Accepting MUL or DIVU goes to BUSY with cnt = 0.
  - BUSY: in_ready = 0. MUL uses shift-add and DIVU uses restoring division, one bit per cycle. Leave for DONE when cnt == WIDTH-1.
  - DONE: out_valid = 1 and outputs are held stable until out_ready. On out_ready, go to IDLE, or take a new request in the same cycle: in_ready = out_ready in DONE.
- Latency:
  - Single-cycle op accepted at cycle t: out_valid at t+1.
  - MUL/DIVU accepted at t: out_valid at t+WIDTH+1.
- Throughput: 1 per cycle for single-cycle ops while out_ready stays high.
- DIVU by 0: ALU_out = all ones, ALU_hi = dividend, div0 = 1, still WIDTH+1 latency.
- kill has priority over every other event. Next state is IDLE, out_valid drops next cycle, and the in-flight result is discarded. An in_valid in the same cycle is ignored.
- Reset (asynchronous, rst_n low):
  - State IDLE; in_ready = 1 after release.
  - out_valid, ALU_out, ALU_hi, zero, ovf, div0, illegal all 0; cnt = 0.
  - Reset mid-BUSY aborts the operation.
- Flags are registered alongside the results and are valid only when out_valid = 1.

Decomposition:
- Package alu_pkg:
  - opcode localparams (OP_ADD … OP_DIVU)
  - state enum {IDLE, BUSY, DONE}
  - helper to classify multi-cycle ops
- Sub-module alu_seq_muldiv:
  - iterative MUL/DIVU datapath (accumulator, shift registers, counter)
  - start/kill/done interface
  - the top level owns the FSM, the single-cycle datapath and the output registers.

Test Plan (all at WIDTH = 16):
- ADD s1=7FFF, s2=0001, ALUsrc=0 -> cycle t+1: ALU_out=8000, ovf=1, zero=0; SUB 0005-0005 -> ALU_out=0000, zero=1.
- ALUsrc=1 with im=FFFF, SRA s1=8000 (shift amount F) -> ALU_out=FFFF; SLT 8000 vs 0001 -> ALU_out=0001.
- MUL 1234*0100 -> out_valid exactly 17 cycles after acceptance; ALU_out=3400, ALU_hi=0012; in_ready=0 throughout BUSY.
- DIVU 0064/0007 -> ALU_out=000E, ALU_hi=0002. DIVU 0064/0000 -> ALU_out=FFFF, ALU_hi=0064, div0=1.
- Back-pressure: hold out_ready=0 for 5 cycles after an XOR result -> outputs stable; then out_ready=1 with a new in_valid -> accepted that cycle, next result 1 cycle later. Opcode 1111 -> ALU_out=DEAD, illegal=1.
- Assert kill at cycle 8 of a MUL, and separately pull rst_n low mid-BUSY -> IDLE, no out_valid, in_ready=1. A following ADD completes correctly.
